// File: rtl/wptr_ctrl_stat.sv
// Write-side pointer controller for the async FIFO: binary/Gray write pointers,
// registered full, occupancy, almost-full, write-accept pulse and sticky overflow.
module wptr_ctrl_stat #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   g_rptr_sync,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH:0]   b_wptr,
    output logic [ADDR_WIDTH:0]   g_wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wr_ack,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic          accept;
    logic [PW-1:0] b_wptr_next;
    logic [PW-1:0] g_wptr_next;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] wcount_next;
    logic          full_next;
    logic          almost_full_next;
    logic          overflow_next;

    // Next-state pointer and status computation, all from registered full
    always_comb begin
        accept           = w_en & ~full;
        b_wptr_next      = b_wptr + {{ADDR_WIDTH{1'b0}}, accept};
        g_wptr_next      = bin2gray(b_wptr_next);
        rptr_bin         = gray2bin(g_rptr_sync);
        wcount_next      = b_wptr_next - rptr_bin;
        // Full when write pointer is exactly one lap ahead: top two Gray bits inverted
        full_next        = (g_wptr_next == {~g_rptr_sync[PW-1:PW-2], g_rptr_sync[PW-3:0]});
        almost_full_next = (af_thresh != '0) && (wcount_next >= af_thresh);
        // Set dominates clear so a rejected write is never lost
        overflow_next    = (w_en & full) | (overflow & ~ovf_clr);
    end

    // Register stage: pointers and status update on the same edge
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            wr_ack      <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wcount      <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_wptr_next;
            g_wptr      <= g_wptr_next;
            wr_ack      <= accept;
            full        <= full_next;
            almost_full <= almost_full_next;
            wcount      <= wcount_next;
            overflow    <= overflow_next;
        end
    end

    assign waddr = b_wptr[ADDR_WIDTH-1:0];

endmodule
